// File: rtl/contactor_pkg.sv
// Shared contactor definitions: FSM state encoding and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package contactor_pkg;

  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_CLOSING = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_OPENING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_T_CLOSE    = 100;
  localparam int DEF_T_OPEN     = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contactor_ctrl_if.sv
// Operator/interlock/feedback bundle of one contactor channel.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels sampled every cycle.
interface contactor_ctrl_if;
  logic       i_req;
  logic       i_permit;
  logic       i_fb;
  logic       i_fault_clr;
  logic       o_coil;
  logic       o_fb;
  logic       o_fault;
  logic [2:0] o_state;

  modport master (
    output i_req, i_permit, i_fb, i_fault_clr,
    input  o_coil, o_fb, o_fault, o_state
  );

  modport slave (
    input  i_req, i_permit, i_fb, i_fault_clr,
    output o_coil, o_fb, o_fault, o_state
  );
endinterface

// File: rtl/contactor_ctrl_fb_debounce.sv
// Aux-contact feedback conditioning: 2-flop synchroniser plus optional debounce (CONTACTOR_DEBOUNCE_EN).
// Latency: 2 cycles raw-to-o_fb; with debounce, o_fb flips after DEB_CYCLES stable differing cycles.
// Backpressure: none; free-running.
module fb_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_fb,
  output logic o_fb
);
  logic sync1, sync2;

  // bring the asynchronous contact level into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_fb;
      sync2 <= sync1;
    end
  end

`ifdef CONTACTOR_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          fb_q;

  // count consecutive disagreeing cycles; any agreement (bounce) restarts the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt  <= '0;
      fb_q <= 1'b0;
    end else if (sync2 == fb_q) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      fb_q <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_fb = fb_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES != 0);
  assign o_fb       = sync2;
`endif

endmodule

// File: rtl/contactor_ctrl.sv
// Contactor sequencer: drives the coil from request/permit and supervises aux feedback with close/open timeouts.
// Latency: coil follows a sampled req&permit or permit loss by exactly one cycle; reset drops coil asynchronously.
// Backpressure: none; FAULT latches until acknowledged with contact open and request removed.
module contactor_ctrl
  import contactor_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int T_CLOSE    = DEF_T_CLOSE,
  parameter int T_OPEN     = DEF_T_OPEN
) (
  input logic             i_clk,
  input logic             i_rst,
  contactor_ctrl_if.slave bus
);
  localparam int T_MAX = max_int(T_CLOSE, T_OPEN);
  localparam int TW    = $clog2(T_MAX + 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          fb_deb;
  logic          coil, fault;
  logic          close_ok, t_close_hit, t_open_hit;

  fb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_fb_debounce (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_fb  (bus.i_fb),
    .o_fb  (fb_deb)
  );

  assign close_ok    = bus.i_req & bus.i_permit;
  // timer holds completed cycles in the phase, so the edge ending the T-th cycle is timer == T-1
  assign t_close_hit = (timer == TW'(T_CLOSE - 1));
  assign t_open_hit  = (timer == TW'(T_OPEN - 1));

  // state register; async reset forces OPEN so the coil drops without a clock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_OPEN;
    else       state <= state_nxt;
  end

  // phase timer: cleared on every state entry, saturating count while CLOSING/OPENING
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      timer <= '0;
    end else if ((state == ST_CLOSING || state == ST_OPENING) && timer != TW'(T_MAX)) begin
      timer <= timer + TW'(1);
    end
  end

  // next-state and Moore outputs; permit/request loss outranks timeouts
  always_comb begin
    state_nxt = state;
    coil      = 1'b0;
    fault     = 1'b0;
    case (state)
      ST_OPEN: begin
        if (close_ok)    state_nxt = ST_CLOSING;
        else if (fb_deb) state_nxt = ST_FAULT;
      end
      ST_CLOSING: begin
        coil = 1'b1;
        if (!close_ok)        state_nxt = ST_OPENING;
        else if (fb_deb)      state_nxt = ST_CLOSED;
        else if (t_close_hit) state_nxt = ST_FAULT;
      end
      ST_CLOSED: begin
        coil = 1'b1;
        if (!close_ok)    state_nxt = ST_OPENING;
        else if (!fb_deb) state_nxt = ST_FAULT;
      end
      ST_OPENING: begin
        if (!fb_deb)         state_nxt = ST_OPEN;
        else if (t_open_hit) state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        fault = 1'b1;
        if (bus.i_fault_clr && !fb_deb && !bus.i_req) state_nxt = ST_OPEN;
      end
      default: state_nxt = ST_FAULT;
    endcase
  end

  assign bus.o_coil  = coil;
  assign bus.o_fb    = fb_deb;
  assign bus.o_fault = fault;
  assign bus.o_state = state;

endmodule

// File: tb/tb_contactor_ctrl.sv
// Self-checking bench for contactor_ctrl: directed scenarios plus randomised plant, against a cycle model.
// Latency: model and DUT both advance on the rising edge; outputs are compared on the falling edge.
// Backpressure: n/a.
module tb_contactor_ctrl;
  import contactor_pkg::*;

  localparam int DEB = 4;
  localparam int TC  = 100;
  localparam int TO  = 100;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  contactor_ctrl_if bus();

  contactor_ctrl #(.DEB_CYCLES(DEB), .T_CLOSE(TC), .T_OPEN(TO)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // states by their specified numbers: 0 open, 1 closing, 2 closed, 3 opening, 4 fault
  int m_state;
  int m_cnt;          // cycles completed in the current state
  bit m_s1, m_s2;     // raw feedback seen one and two edges ago
  bit m_fb;           // expected conditioned feedback
  bit hist[$];        // recent synchronised samples, newest last
  bit [15:0] coil_hist;

  function automatic bit m_coil();
    return (m_state == 1 || m_state == 2);
  endfunction

  task automatic model_step();
    int nxt;
    bit new_fb;
    bit all_diff;
    bit ok;
    ok  = bus.i_req && bus.i_permit;
    nxt = m_state;
    case (m_state)
      0: if (ok) nxt = 1; else if (m_fb) nxt = 4;
      1: if (!ok) nxt = 3; else if (m_fb) nxt = 2; else if (m_cnt + 1 >= TC) nxt = 4;
      2: if (!ok) nxt = 3; else if (!m_fb) nxt = 4;
      3: if (!m_fb) nxt = 0; else if (m_cnt + 1 >= TO) nxt = 4;
      default: if (bus.i_fault_clr && !m_fb && !bus.i_req) nxt = 0;
    endcase
    m_cnt   = (nxt != m_state) ? 0 : m_cnt + 1;
    m_state = nxt;
`ifdef CONTACTOR_DEBOUNCE_EN
    hist.push_back(m_s2);
    if (hist.size() > DEB) void'(hist.pop_front());
    new_fb = m_fb;
    if (hist.size() == DEB) begin
      all_diff = 1'b1;
      foreach (hist[i]) if (hist[i] == m_fb) all_diff = 1'b0;
      if (all_diff) new_fb = !m_fb;
    end
`else
    new_fb = m_s1;
`endif
    m_s2 = m_s1;
    m_s1 = bus.i_fb;
    m_fb = new_fb;
  endtask

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_fb = 0;
      hist.delete();
    end else begin
      model_step();
    end
  end

  task automatic check_outputs();
    check("coil",  bus.o_coil,  m_coil());
    check("fb",    bus.o_fb,    m_fb);
    check("fault", bus.o_fault, (m_state == 4));
    check("state", bus.o_state, m_state);
  endtask

  // call at a falling edge: apply inputs, cross one rising edge, compare
  task automatic tick(input bit req, input bit permit, input bit fb, input bit clr);
    bus.i_req = req; bus.i_permit = permit; bus.i_fb = fb; bus.i_fault_clr = clr;
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
    coil_hist = {coil_hist[14:0], m_coil()};
  endtask

  initial begin
    int len, mode, lag;
    bit req, permit, fb, clr;
    coil_hist = '0;
    bus.i_req = 0; bus.i_permit = 0; bus.i_fb = 0; bus.i_fault_clr = 0;
    i_rst = 1'b1;
    #1;
    check("rst_coil",  bus.o_coil,  0);
    check("rst_fb",    bus.o_fb,    0);
    check("rst_fault", bus.o_fault, 0);
    check("rst_state", bus.o_state, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    #1 check("rel_state", bus.o_state, 0);

    // normal close: feedback arrives 10 cycles after the request
    repeat (10) tick(1, 1, 0, 0);
    repeat (15) tick(1, 1, 1, 0);
    check("close_done", bus.o_state, 2);

    // interlock trip from CLOSED, contact then drops
    tick(1, 0, 1, 0);
    check("trip_coil", bus.o_coil, 0);
    repeat (2) tick(0, 0, 1, 0);
    repeat (8) tick(0, 0, 0, 0);
    check("trip_open", bus.o_state, 0);

    // close timeout with feedback stuck open, then acknowledge
    repeat (105) tick(1, 1, 0, 0);
    check("tmo_state", bus.o_state, 4);
    check("tmo_coil",  bus.o_coil, 0);
    tick(0, 0, 0, 1);
    check("tmo_clr", bus.o_state, 0);

    // bounce: feedback toggles every 2 cycles while open
    for (int i = 0; i < 20; i++) tick(0, 0, ((i / 2) % 2) != 0, 0);
    repeat (10) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);

    // welded contact in OPEN; acknowledge refused while still closed
    repeat (10) tick(0, 0, 1, 0);
    check("weld_fault", bus.o_state, 4);
    repeat (3) tick(0, 0, 1, 1);
    check("weld_hold", bus.o_state, 4);
    repeat (8) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("weld_clr", bus.o_state, 0);

    // asynchronous reset while CLOSED, asserted between edges
    repeat (3) tick(1, 1, 0, 0);
    repeat (10) tick(1, 1, 1, 0);
    check("pre_rst_state", bus.o_state, 2);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    bus.i_req = 0; bus.i_permit = 0; bus.i_fb = 0; bus.i_fault_clr = 0;
    #1;
    check("arst_coil",  bus.o_coil,  0);
    check("arst_state", bus.o_state, 0);
    @(negedge i_clk); @(posedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("post_coil",  bus.o_coil,  0);
    check("post_fb",    bus.o_fb,    0);
    check("post_fault", bus.o_fault, 0);
    check("post_state", bus.o_state, 0);
    coil_hist = '0;

    // randomised segments with a lagging plant, bouncing or stuck feedback
    for (int seg = 0; seg < 60; seg++) begin
      len    = $urandom_range(1, 40);
      req    = ($urandom_range(0, 9) < 7);
      permit = ($urandom_range(0, 9) < 8);
      mode   = $urandom_range(0, 9);
      lag    = $urandom_range(2, 12);
      for (int c = 0; c < len; c++) begin
        if (mode < 6)       fb = coil_hist[lag];
        else if (mode == 6) fb = $urandom_range(0, 1);
        else if (mode == 7) fb = 1'b1;
        else                fb = 1'b0;
        clr = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 29) == 0) permit = !permit;
        if (m_state == 4 && $urandom_range(0, 3) == 0) req = 1'b0;
        tick(req, permit, fb, clr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
